ram_block_copier: RTL

- Sequential DMA engine that copies a block of 16-bit words from one address range to another inside a RAM16K-style memory.
- Sits directly upstream of the RAM16K macro. It drives the memory's enable, address, write, read and data-in pins and consumes its data-out.
- Lets the CPU-side controller hand off bulk moves with a single start pulse.
- Copy is strictly ascending (memcpy semantics, not memmove).

---
 rtl/ram_block_copier_pkg.sv | 20 ++
 rtl/ram_block_copier_ptr.sv | 55 +++++
 rtl/ram_block_copier.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ram_block_copier_pkg.sv
// ram_block_copier_pkg
//   Shared types and default sizes for the RAM16K block copier.
//   state_t    : copier FSM states (IDLE, READ, WRITE, DONE)
//   *_W_DEF    : default address / data / length widths
//   MAX_LEN    : largest legal block length (one full address space)
package ram_block_copier_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 15;
  localparam int MAX_LEN    = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ram_block_copier_ptr.sv
// copier_ptr
//   Source/destination pointers and remaining-word counter of the copier.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     i_load      : capture i_src / i_dst / i_len (length clamped to 2^ADDR_W)
//     i_step      : advance both pointers (wrapping) and decrement the count
//     o_src_ptr   : current source address
//     o_dst_ptr   : current destination address
//     o_last      : the word being handled is the final one (count == 1)
module copier_ptr
  import ram_block_copier_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_src_ptr,
  output logic [ADDR_W-1:0] o_dst_ptr,
  output logic              o_last
);

  localparam logic [LEN_W-1:0] L_MAX_LEN = LEN_W'(1) << ADDR_W;

  logic [ADDR_W-1:0] r_src_ptr;
  logic [ADDR_W-1:0] r_dst_ptr;
  logic [LEN_W-1:0]  r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_ptr <= '0;
      r_dst_ptr <= '0;
      r_count   <= '0;
    end else if (i_load) begin
      r_src_ptr <= i_src;
      r_dst_ptr <= i_dst;
      r_count   <= (i_len > L_MAX_LEN) ? L_MAX_LEN : i_len;
    end else if (i_step) begin
      // Pointer width equals address width, so the increment wraps naturally.
      r_src_ptr <= r_src_ptr + ADDR_W'(1);
      r_dst_ptr <= r_dst_ptr + ADDR_W'(1);
      r_count   <= r_count - LEN_W'(1);
    end
  end

  assign o_src_ptr = r_src_ptr;
  assign o_dst_ptr = r_dst_ptr;
  assign o_last    = (r_count == LEN_W'(1));

endmodule

// File: rtl/ram_block_copier.sv
// ram_block_copier
//   DMA engine that copies a block of words inside a RAM16K-style memory,
//   strictly ascending, two cycles per word (READ then WRITE).
//   Optional feature macro: RAM_BLOCK_COPIER_FILL_EN adds fill/pattern
//   inputs; a fill writes the pattern at one cycle per word with no reads.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     start           : request pulse, honoured only in IDLE
//     src, dst, len   : block source, destination and length (0..2^ADDR_W)
//     busy            : high while in READ or WRITE
//     done            : one-cycle completion pulse
//     mem_e/mem_w/mem_r/mem_addr/mem_din : memory control and write data
//     mem_dout        : memory read data (combinational on mem_addr)
//     fill, pattern   : (FILL_EN only) fill request and fill word
module ram_block_copier
  import ram_block_copier_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              mem_e,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_w,
  output logic              mem_r,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef RAM_BLOCK_COPIER_FILL_EN
  ,
  input  logic              fill,
  input  logic [DATA_W-1:0] pattern
`endif
);

  state_t            r_state;
  logic [DATA_W-1:0] r_buf;
  logic [ADDR_W-1:0] r_addr_hold;
  logic              r_fill;

  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_fill_req;
  logic [DATA_W-1:0] w_pattern;
  logic [ADDR_W-1:0] w_src_ptr;
  logic [ADDR_W-1:0] w_dst_ptr;

`ifdef RAM_BLOCK_COPIER_FILL_EN
  assign w_fill_req = fill;
  assign w_pattern  = pattern;
`else
  assign w_fill_req = 1'b0;
  assign w_pattern  = '0;
`endif

  assign w_load = (r_state == IDLE) && start && (len != '0);
  assign w_step = (r_state == WRITE);

  copier_ptr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_src     (src),
    .i_dst     (dst),
    .i_len     (len),
    .o_src_ptr (w_src_ptr),
    .o_dst_ptr (w_dst_ptr),
    .o_last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_buf       <= '0;
      r_fill      <= 1'b0;
      r_addr_hold <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_state <= DONE;
            end else begin
              r_fill <= w_fill_req;
              // A fill preloads the word buffer with the pattern so the
              // WRITE state drives mem_din identically for copy and fill.
              if (w_fill_req) begin
                r_buf   <= w_pattern;
                r_state <= WRITE;
              end else begin
                r_state <= READ;
              end
            end
          end
        end
        READ: begin
          r_buf       <= mem_dout;
          r_addr_hold <= w_src_ptr;
          r_state     <= WRITE;
        end
        WRITE: begin
          r_addr_hold <= w_dst_ptr;
          if (w_last)      r_state <= DONE;
          else if (r_fill) r_state <= WRITE;
          else             r_state <= READ;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Moore decode; mem_addr falls back to the last address driven so it
  // holds steady while idle.
  always_comb begin
    busy     = (r_state == READ) || (r_state == WRITE);
    done     = (r_state == DONE);
    mem_e    = busy;
    mem_r    = (r_state == READ);
    // Gate with rst so a write in flight on the reset edge never lands.
    mem_w    = (r_state == WRITE) && !rst;
    mem_din  = r_buf;
    mem_addr = r_addr_hold;
    if (r_state == READ)  mem_addr = w_src_ptr;
    if (r_state == WRITE) mem_addr = w_dst_ptr;
  end

endmodule
